// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external RV32I ALU between two requesters.
// Operands are registered onto the ALU, result/flags captured one cycle later.
//
// state     | meaning
// ST_IDLE   | arbitrating; reqN_ready follows grant
// ST_EXEC   | ALU settling on registered operands; capture at end of cycle
// ST_RESP   | result held for owner until its resp ready
module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_funct3,
  input  logic             req0_sign,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_funct3,
  input  logic             req1_sign,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [31:0]      resp0_result,
  output logic [2:0]       resp0_flags,
  output logic [TAG_W-1:0] resp0_tag,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [31:0]      resp1_result,
  output logic [2:0]       resp1_flags,
  output logic [TAG_W-1:0] resp1_tag,
  output logic             busy,
  output logic [31:0]      alu_op_a,
  output logic [31:0]      alu_op_b,
  output logic [2:0]       alu_funct3,
  output logic             alu_op_sign,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_negative,
  input  logic             alu_overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             owner;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic [31:0]      resp_result_q;
  logic [2:0]       resp_flags_q;
  logic             grant0;
  logic             grant1;
  logic             owner_ready;

  // Contention goes to the port that did not win last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign owner_ready = owner ? resp1_ready : resp0_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      tag_q         <= '0;
      resp_tag_q    <= '0;
      resp_result_q <= '0;
      resp_flags_q  <= '0;
      alu_op_a      <= '0;
      alu_op_b      <= '0;
      alu_funct3    <= '0;
      alu_op_sign   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0) begin
            alu_op_a    <= req0_a;
            alu_op_b    <= req0_b;
            alu_funct3  <= req0_funct3;
            alu_op_sign <= req0_sign;
            tag_q       <= req0_tag;
            owner       <= 1'b0;
            last_grant  <= 1'b0;
            state       <= ST_EXEC;
          end else if (grant1) begin
            alu_op_a    <= req1_a;
            alu_op_b    <= req1_b;
            alu_funct3  <= req1_funct3;
            alu_op_sign <= req1_sign;
            tag_q       <= req1_tag;
            owner       <= 1'b1;
            last_grant  <= 1'b1;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_result_q <= alu_result;
          resp_flags_q  <= {alu_overflow, alu_negative, alu_zero};
          resp_tag_q    <= tag_q;
          state         <= ST_RESP;
        end
        ST_RESP: begin
          if (owner_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = (state != ST_IDLE);
  assign resp0_valid  = (state == ST_RESP) && !owner;
  assign resp1_valid  = (state == ST_RESP) && owner;
  assign resp0_result = resp_result_q;
  assign resp1_result = resp_result_q;
  assign resp0_flags  = resp_flags_q;
  assign resp1_flags  = resp_flags_q;
  assign resp0_tag    = resp_tag_q;
  assign resp1_tag    = resp_tag_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural RV32I ALU attached
// to the alu_* ports; expected results are hand-computed constants.
module tb_alu_share_arbiter;
  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic             req0_valid, req0_ready, req0_sign;
  logic [31:0]      req0_a, req0_b;
  logic [2:0]       req0_funct3;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid, req1_ready, req1_sign;
  logic [31:0]      req1_a, req1_b;
  logic [2:0]       req1_funct3;
  logic [TAG_W-1:0] req1_tag;
  logic             resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0]      resp0_result, resp1_result;
  logic [2:0]       resp0_flags, resp1_flags;
  logic [TAG_W-1:0] resp0_tag, resp1_tag;
  logic             busy;
  logic [31:0]      alu_op_a, alu_op_b, alu_result;
  logic [2:0]       alu_funct3;
  logic             alu_op_sign, alu_zero, alu_negative, alu_overflow;

  alu_share_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_funct3(req0_funct3), .req0_sign(req0_sign), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_funct3(req1_funct3), .req1_sign(req1_sign), .req1_tag(req1_tag),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
    .resp0_flags(resp0_flags), .resp0_tag(resp0_tag),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
    .resp1_flags(resp1_flags), .resp1_tag(resp1_tag),
    .busy(busy), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_funct3(alu_funct3),
    .alu_op_sign(alu_op_sign), .alu_result(alu_result), .alu_zero(alu_zero),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow)
  );

  // Combinational ALU standing in for the external datapath.
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_funct3)
      3'b000: begin
        alu_result = alu_op_sign ? alu_op_a - alu_op_b : alu_op_a + alu_op_b;
        alu_overflow = alu_op_sign
          ? (alu_op_a[31] != alu_op_b[31]) && (alu_result[31] != alu_op_a[31])
          : (alu_op_a[31] == alu_op_b[31]) && (alu_result[31] != alu_op_a[31]);
      end
      3'b001: alu_result = alu_op_a << alu_op_b[4:0];
      3'b010: alu_result = {31'd0, $signed(alu_op_a) < $signed(alu_op_b)};
      3'b011: alu_result = {31'd0, alu_op_a < alu_op_b};
      3'b100: alu_result = alu_op_a ^ alu_op_b;
      3'b101: alu_result = alu_op_sign ? 32'($signed(alu_op_a) >>> alu_op_b[4:0])
                                       : alu_op_a >> alu_op_b[4:0];
      3'b110: alu_result = alu_op_a | alu_op_b;
      default: alu_result = alu_op_a & alu_op_b;
    endcase
    alu_zero     = (alu_result == 32'd0);
    alu_negative = alu_result[31];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input int port, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f3, input logic sg, input logic [3:0] tg);
    if (port == 0) begin
      req0_a = a; req0_b = b; req0_funct3 = f3; req0_sign = sg; req0_tag = tg; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_funct3 = f3; req1_sign = sg; req1_tag = tg; req1_valid = 1'b1;
    end
  endtask

  // Full solo transaction starting and ending at a negedge in IDLE.
  task automatic run_op(input string name, input int port, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] f3, input logic sg,
                        input logic [3:0] tg, input logic [31:0] exp_res,
                        input logic [2:0] exp_flags);
    drive_req(port, a, b, f3, sg, tg);
    #1;
    check({name, " ready0"}, req0_ready, port == 0);
    check({name, " ready1"}, req1_ready, port == 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check({name, " busy_exec"}, busy, 1);
    check({name, " alu_a"}, alu_op_a, a);
    check({name, " alu_b"}, alu_op_b, b);
    check({name, " alu_f3"}, alu_funct3, f3);
    check({name, " alu_sign"}, alu_op_sign, sg);
    check({name, " no_resp_exec"}, resp0_valid | resp1_valid, 0);
    tick();
    #1;
    check({name, " resp0_valid"}, resp0_valid, port == 0);
    check({name, " resp1_valid"}, resp1_valid, port == 1);
    check({name, " result"}, port == 0 ? resp0_result : resp1_result, exp_res);
    check({name, " flags"}, port == 0 ? resp0_flags : resp1_flags, exp_flags);
    check({name, " tag"}, port == 0 ? resp0_tag : resp1_tag, tg);
    if (port == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    tick();
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    #1;
    check({name, " resp_cleared"}, resp0_valid | resp1_valid, 0);
    check({name, " idle"}, busy, 0);
  endtask

  initial begin
    resetn = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_funct3 = 0; req0_sign = 0; req0_tag = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_funct3 = 0; req1_sign = 0; req1_tag = 0;
    resp0_ready = 0; resp1_ready = 0;
    #2;
    check("rst busy", busy, 0);
    check("rst resp0_valid", resp0_valid, 0);
    check("rst resp1_valid", resp1_valid, 0);
    check("rst alu_a", alu_op_a, 0);
    check("rst alu_b", alu_op_b, 0);
    check("rst alu_f3", alu_funct3, 0);
    check("rst alu_sign", alu_op_sign, 0);
    check("rst result", resp0_result, 0);
    check("rst flags", resp1_flags, 0);
    check("rst tag", resp0_tag, 0);
    check("rst ready0", req0_ready, 0);
    tick(); tick();
    resetn = 1'b1;

    // First contention after reset goes to port 0
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("first_cont ready0", req0_ready, 1);
    check("first_cont ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    run_op("add", 0, 32'd12, 32'd13, 3'b000, 1'b0, 4'd3, 32'h0000_0019, 3'b000);
    run_op("sub", 1, 32'd11, 32'd13, 3'b000, 1'b1, 4'd5, 32'hFFFF_FFFE, 3'b010);

    // Both held valid: grants alternate 0,1,0,1
    drive_req(0, 32'h1000_0000, 32'd2, 3'b001, 1'b0, 4'd1);
    drive_req(1, 32'hFFFF_0000, 32'h0000_FFFF, 3'b100, 1'b0, 4'd2);
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("cont ready0", req0_ready, (k % 2) == 0);
      check("cont ready1", req1_ready, (k % 2) == 1);
      tick();
      #1;
      check("cont alu_a", alu_op_a, (k % 2) == 0 ? 32'h1000_0000 : 32'hFFFF_0000);
      tick();
      #1;
      check("cont resp0_valid", resp0_valid, (k % 2) == 0);
      check("cont resp1_valid", resp1_valid, (k % 2) == 1);
      check("cont result", (k % 2) == 0 ? resp0_result : resp1_result,
            (k % 2) == 0 ? 32'h4000_0000 : 32'hFFFF_FFFF);
      check("cont flags", resp0_flags, (k % 2) == 0 ? 3'b000 : 3'b010);
      check("cont tag", resp1_tag, (k % 2) == 0 ? 4'd1 : 4'd2);
      check("cont no_ready_resp", req0_ready | req1_ready, 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;

    // Backpressure on port 0 with port 1 waiting
    drive_req(0, 32'd7, 32'd9, 3'b110, 1'b0, 4'd9);
    drive_req(1, 32'd1, 32'd1, 3'b000, 1'b0, 4'd2);
    #1;
    check("bp ready0", req0_ready, 1);
    check("bp ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    check("bp resp0_valid", resp0_valid, 1);
    check("bp result", resp0_result, 32'h0000_000F);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      check("bp hold valid", resp0_valid, 1);
      check("bp hold result", resp0_result, 32'h0000_000F);
      check("bp hold flags", resp0_flags, 3'b000);
      check("bp hold tag", resp0_tag, 4'd9);
      check("bp busy", busy, 1);
      check("bp ready1", req1_ready, 0);
    end
    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    #1;
    check("bp released valid", resp0_valid, 0);
    check("bp resume ready1", req1_ready, 1);
    req1_valid = 1'b0;
    tick();

    // Reset during EXEC discards the operation
    drive_req(0, 32'h100, 32'h200, 3'b000, 1'b0, 4'hA);
    #1;
    check("rstmid ready0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    check("rstmid exec busy", busy, 1);
    check("rstmid exec alu_a", alu_op_a, 32'h100);
    resetn = 1'b0;
    #1;
    check("rstmid busy", busy, 0);
    check("rstmid alu_a", alu_op_a, 0);
    check("rstmid alu_b", alu_op_b, 0);
    check("rstmid result", resp0_result, 0);
    check("rstmid tag", resp0_tag, 0);
    check("rstmid resp0_valid", resp0_valid, 0);
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("rstmid no_resp", resp0_valid | resp1_valid, 0);
      check("rstmid idle", busy, 0);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rstmid cont ready0", req0_ready, 1);
    check("rstmid cont ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    run_op("sra", 0, 32'hFFFF_0001, 32'd2, 3'b101, 1'b1, 4'd6, 32'hFFFF_C000, 3'b010);
    run_op("zero", 1, 32'd5, 32'd5, 3'b000, 1'b1, 4'd7, 32'h0000_0000, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
